seq_sum: RTL

Parametrised multi-cycle adder/subtractor, the sequential successor of the team's combinational 5-bit `my_sum`/`ref_sum` adders. Operands are captured on a start strobe and summed DIGIT bits per clock through a registered carry, with add/subtract mode, carry-out and signed-overflow flags. It sits behind a simple start/done handshake, so a testbench or controller can drive it and compare the result against `ref_sum` at WIDTH=5.

---
 rtl/seq_sum_if.sv | 33 +++
 rtl/seq_sum.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/seq_sum_if.sv
//==============================================================================
// Module      : seq_sum_if
// Description : Start/done handshake and operand/result bundle for seq_sum.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface seq_sum_if #(
    parameter int WIDTH = 5
);
    logic             start;
    logic [WIDTH-1:0] ain;
    logic [WIDTH-1:0] bin;
    logic             ci;
    logic             mode;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] res;
    logic             co;
    logic             ovf;

    modport master (
        output start, ain, bin, ci, mode,
        input  busy, done, res, co, ovf
    );

    modport slave (
        input  start, ain, bin, ci, mode,
        output busy, done, res, co, ovf
    );
endinterface

`default_nettype wire

// File: rtl/seq_sum.sv
//==============================================================================
// Module      : seq_sum
// Description : Multi-cycle add/subtract, DIGIT bits per clock with carry,
//               carry-out and signed-overflow flags.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module seq_sum #(
    parameter int WIDTH = 5,
    parameter int DIGIT = 1
) (
    input  wire logic  clk,
    input  wire logic  rst_n,
    seq_sum_if.slave   bus
);

    localparam int                N       = WIDTH / DIGIT;
    localparam int                CNT_W   = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0]  C_LAST  = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0]  C_ONE   = CNT_W'(1);

    generate
        if ((WIDTH % DIGIT) != 0 || WIDTH < 2) begin : g_bad_params
            $error("seq_sum: WIDTH must be >= 2 and a multiple of DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic              accept;
    logic              last_digit;

    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic [WIDTH-1:0]  acc_q;
    logic [WIDTH-1:0]  acc_d;
    logic [WIDTH-1:0]  res_q;
    logic              carry_q;
    logic              co_q;
    logic              ovf_q;
    logic [CNT_W-1:0]  cnt_q;

    logic [DIGIT-1:0]  dig_a;
    logic [DIGIT-1:0]  dig_b;
    logic [DIGIT-1:0]  dig_s;
    logic [DIGIT:0]    cy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A start seen in DONE is taken immediately so back-to-back ops lose no cycle.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    accept  = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (last_digit) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.start) begin
                    accept  = 1'b1;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign last_digit = (cnt_q == C_LAST);

    // Bit-serial ripple inside the digit keeps the carry into the MSB visible for ovf.
    always_comb begin
        dig_a = a_q[int'(cnt_q) * DIGIT +: DIGIT];
        dig_b = b_q[int'(cnt_q) * DIGIT +: DIGIT];
        dig_s = '0;
        cy    = '0;
        cy[0] = carry_q;
        for (int k = 0; k < DIGIT; k++) begin
            dig_s[k]  = dig_a[k] ^ dig_b[k] ^ cy[k];
            cy[k+1]   = (dig_a[k] & dig_b[k]) | (cy[k] & (dig_a[k] ^ dig_b[k]));
        end
        acc_d = acc_q;
        acc_d[int'(cnt_q) * DIGIT +: DIGIT] = dig_s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            co_q    <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else if (accept) begin
            // Subtraction is A + ~B + ~borrow, so co reads as "no borrow".
            a_q     <= bus.ain;
            b_q     <= bus.mode ? ~bus.bin : bus.bin;
            carry_q <= bus.mode ? ~bus.ci : bus.ci;
            cnt_q   <= '0;
            acc_q   <= '0;
        end else if (state_q == S_RUN) begin
            acc_q   <= acc_d;
            carry_q <= cy[DIGIT];
            cnt_q   <= cnt_q + C_ONE;
            if (last_digit) begin
                res_q <= acc_d;
                co_q  <= cy[DIGIT];
                ovf_q <= cy[DIGIT] ^ cy[DIGIT-1];
            end
        end
    end

    assign bus.busy = (state_q == S_RUN);
    assign bus.done = (state_q == S_DONE);
    assign bus.res  = res_q;
    assign bus.co   = co_q;
    assign bus.ovf  = ovf_q;

endmodule

`default_nettype wire
